mem_twoport_fifo_ctrl: RTL and testbench
========================================

// Module: mem_twoport_fifo_ctrl
// PURPOSE
//  Drives the 512x20 single-clock two-port RAM (ra/wa/write/d -> q) to form a FIFO.
//  Valid/ready streams on both sides. RAM sits outside this block.
//  RAM rule: a write cycle does not read (q holds); one RAM op per cycle. The block arbitrates.
//  A 2-entry output buffer absorbs the 1-cycle RAM read latency, so output stalls never lose data.
// PARAMETERS
//  AW     9        RAM address width
//  DW     20       data width
//  DEPTH  2**AW    RAM entries (512); total capacity DEPTH+2 incl. output buffer
// PORTS
//  clk        in   1    single clock, all state on posedge
//  reset      in   1    asynchronous, active-high
//  in_valid   in   1    producer has in_data
//  in_ready   out  1    block accepts in_data this cycle
//  in_data    in   DW   write payload
//  out_valid  out  1    out_data valid
//  out_ready  in   1    consumer takes out_data
//  out_data   out  DW   head of FIFO
//  mem_ra     out  AW   RAM read address (= rd_ptr)
//  mem_wa     out  AW   RAM write address (= wr_ptr)
//  mem_write  out  1    RAM write enable
//  mem_d      out  DW   RAM write data (= in_data)
//  mem_q      in   DW   RAM read data, valid the cycle after a non-write cycle
//  count      out  AW+1 words held: mem_cnt + pend + ob_cnt (0..DEPTH+2), registered
// BEHAVIOUR
//  State: wr_ptr, rd_ptr (AW, wrap DEPTH-1->0 naturally); mem_cnt (AW+1, 0..DEPTH);
//   pend (read issued last cycle); ob_cnt (0..2); rd_turn (arbitration flag).
//  Reset (async): all state 0; out_valid=0, count=0; in_ready=0 and mem_write=0 while reset high.
//  fetch_needed = mem_cnt!=0 && (ob_cnt + pend + 0) < 2 counted after this cycle's pop.
//  rd_issue  = fetch_needed && (rd_turn || !in_valid)   (combinational)
//  in_ready  = !reset && mem_cnt!=DEPTH && !rd_issue    (may depend on in_valid)
//  mem_write = in_valid && in_ready; never asserted in the same cycle as rd_issue.
//  Write accept: wr_ptr++, mem_cnt++, rd_turn<=1.
//  Read issue: mem_write=0, mem_ra=rd_ptr; rd_ptr++, mem_cnt--, pend<=1, rd_turn<=0.
//  pend=1: mem_q is pushed into the output buffer at this edge; pend<=0 unless re-issued.
//  Output buffer: 2-entry FIFO; out_valid = ob_cnt!=0; pop on out_valid&&out_ready.
//   Push and pop in one cycle leave ob_cnt unchanged. Buffer never overflows (fetch_needed guard).
//  Latency: word accepted into an empty FIFO at edge E0 -> out_valid high after E2.
//  Throughput with both sides streaming: reads and writes alternate, 1 word per 2 cycles each.
//   With in_valid=0, reads issue back-to-back.
//  Full: mem_cnt==DEPTH -> in_ready=0; reads continue. Empty: mem_cnt==0 -> no read issued.
//  Simultaneous accept+read: impossible by construction. Accept+pop in one cycle: count unchanged.
//  out_data stable while out_valid && !out_ready.
//  Reset mid-operation: pointers/counts cleared; buffered data discarded; RAM contents untouched.
// STRUCTURE
//  Package mem_pkg: AW, DW, DEPTH localparams; typedef addr_t [AW-1:0], data_t [DW-1:0].
//  Sub-module: fifo_out_buf (2-entry valid/ready buffer: push, din, pop, dout, cnt).
//  Top: pointers, counters, arbitration. RAM instantiated beside this block, not inside it.
// TESTING (bench includes a behavioural model of the RAM write/read-hold rule)
//  1. Reset, push 20'h12345 at E0 -> mem_wa=0, mem_write=1; out_valid after E2, data 20'h12345, count=1.
//  2. out_ready=0, push 514 words -> in_ready=0 at count=514 (mem_cnt=512); no further mem_write.
//  3. in_valid=out_ready=1, incrementing data -> mem_write alternates with reads; output in order.
//  4. Push/pop 1000 incrementing words, random stalls -> mem_wa/mem_ra wrap 511->0; no loss, no reorder.
//  5. out_ready toggling 1/0 with 2 buffered words -> out_data held while stalled; count exact each cycle.
//  6. Assert reset for 1 cycle mid-stream with count=7 -> out_valid=0, count=0 next edge; new data flows from wa=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths and types for the two-port-RAM FIFO controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;
    localparam int AW    = 9;
    localparam int DW    = 20;
    localparam int DEPTH = 2 ** AW;

    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] data_t;
    typedef logic [AW:0]   cnt_t;
endpackage

// File: rtl/mem_twoport_fifo_ctrl_if.sv
// Stream and RAM-port bundle for the FIFO controller; slave is the controller's view.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry valid-ready flow control in each direction.
interface mem_twoport_fifo_ctrl_if;
    import mem_pkg::*;

    logic  in_valid;
    logic  in_ready;
    data_t in_data;
    logic  out_valid;
    logic  out_ready;
    data_t out_data;
    addr_t mem_ra;
    addr_t mem_wa;
    logic  mem_write;
    data_t mem_d;
    data_t mem_q;
    cnt_t  count;

    modport slave (
        input  in_valid, in_data, out_ready, mem_q,
        output in_ready, out_valid, out_data, mem_ra, mem_wa, mem_write, mem_d, count
    );

    modport master (
        output in_valid, in_data, out_ready, mem_q,
        input  in_ready, out_valid, out_data, mem_ra, mem_wa, mem_write, mem_d, count
    );
endinterface

// File: rtl/mem_twoport_fifo_ctrl_fifo_out_buf.sv
// Two-entry output buffer that catches RAM read data; entry 0 is always the head.
// Latency: pushed word is visible on dout the cycle after the push edge.
// Backpressure: none internally; the caller must never push into a full buffer without popping.
module fifo_out_buf
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  data_t      din,
    input  logic       pop,
    output data_t      dout,
    output logic [1:0] cnt
);
    data_t      e0_q, e0_d;
    data_t      e1_q, e1_d;
    logic [1:0] cnt_q, cnt_d;

    // Next-state: shift on pop, fill the first free slot on push.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = din;
                else               e1_d = din;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    e0_d = din;
                end else begin
                    e0_d = e1_q;
                    e1_d = din;
                end
            end
            default: ;
        endcase
    end

    // State registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout = e0_q;
    assign cnt  = cnt_q;
endmodule

// File: rtl/mem_twoport_fifo_ctrl.sv
// FIFO controller around an external 512x20 two-port RAM, one RAM op (write or read) per cycle.
// Latency: word accepted at edge E0 appears on out_valid after edge E2.
// Backpressure: in_ready drops when the RAM is full or a read wins arbitration; output stalls are absorbed by a 2-entry buffer.
module mem_twoport_fifo_ctrl
    import mem_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    mem_twoport_fifo_ctrl_if.slave bus
);
    addr_t      wr_ptr_q, wr_ptr_d;
    addr_t      rd_ptr_q, rd_ptr_d;
    cnt_t       mem_cnt_q, mem_cnt_d;
    cnt_t       count_q, count_d;
    logic       pend_q, pend_d;
    logic       rd_turn_q, rd_turn_d;

    logic [1:0] ob_cnt;
    data_t      ob_dout;
    logic [2:0] ob_room;
    logic       pop;
    logic       fetch_needed;
    logic       rd_issue;
    logic       in_ready_c;
    logic       wr_accept;

    // Arbitration: a read is needed only if its data will still fit in the buffer
    // after this cycle's pop and any read already in flight; reads and writes take turns.
    always_comb begin
        pop          = (ob_cnt != 2'd0) && bus.out_ready;
        ob_room      = {1'b0, ob_cnt} - {2'b00, pop} + {2'b00, pend_q};
        fetch_needed = (mem_cnt_q != '0) && (ob_room < 3'd2);
        rd_issue     = fetch_needed && (rd_turn_q || !bus.in_valid);
        in_ready_c   = !reset && (mem_cnt_q != cnt_t'(DEPTH)) && !rd_issue;
        wr_accept    = bus.in_valid && in_ready_c;
    end

    // Pointer, occupancy and turn-flag updates; accept and read issue are mutually exclusive.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_cnt_d = mem_cnt_q;
        rd_turn_d = rd_turn_q;
        pend_d    = rd_issue;
        count_d   = count_q + cnt_t'(wr_accept) - cnt_t'(pop);
        if (wr_accept) begin
            wr_ptr_d  = wr_ptr_q + addr_t'(1);
            mem_cnt_d = mem_cnt_q + cnt_t'(1);
            rd_turn_d = 1'b1;
        end else if (rd_issue) begin
            rd_ptr_d  = rd_ptr_q + addr_t'(1);
            mem_cnt_d = mem_cnt_q - cnt_t'(1);
            rd_turn_d = 1'b0;
        end
    end

    // State registers; reset discards everything except the RAM contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            count_q   <= '0;
            pend_q    <= 1'b0;
            rd_turn_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
            rd_turn_q <= rd_turn_d;
        end
    end

    // RAM read data from last cycle's read lands in the output buffer at this edge.
    fifo_out_buf u_out_buf (
        .clk   (clk),
        .reset (reset),
        .push  (pend_q),
        .din   (bus.mem_q),
        .pop   (pop),
        .dout  (ob_dout),
        .cnt   (ob_cnt)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.mem_write = wr_accept;
    assign bus.mem_wa    = wr_ptr_q;
    assign bus.mem_ra    = rd_ptr_q;
    assign bus.mem_d     = bus.in_data;
    assign bus.out_valid = (ob_cnt != 2'd0);
    assign bus.out_data  = ob_dout;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_mem_twoport_fifo_ctrl.sv
// Bench for the two-port-RAM FIFO controller: RAM model, queue reference, random stalls.
// Latency: checks E0 -> E2 first-word latency and 1-per-2-cycle streaming rate.
// Backpressure: exercises full, stalled-output hold and mid-stream reset.
module tb_mem_twoport_fifo_ctrl;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_twoport_fifo_ctrl_if bus ();

    mem_twoport_fifo_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM model: a write cycle stores and leaves q alone, any other cycle reads ra.
    data_t ram [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_write) ram[bus.mem_wa] <= bus.mem_d;
        else               bus.mem_q       <= ram[bus.mem_ra];
    end

    int    checks   = 0;
    int    failures = 0;
    data_t model_q[$];
    int    wr_total  = 0;
    int    pop_total = 0;
    logic  prev_stall = 1'b0;
    data_t prev_data  = '0;
    data_t next_data  = 20'h12345;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: sample at the falling edge, update the reference, return just after the rising edge.
    task automatic cycle();
        logic acc;
        logic pp;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        pp  = bus.out_valid && bus.out_ready;
        check("wr_en", bus.mem_write, acc);
        check("count", bus.count, model_q.size());
        if (model_q.size() >= DEPTH + 2) check("full_rdy", bus.in_ready, 0);
        if (acc) begin
            check("wa", bus.mem_wa, wr_total % DEPTH);
            check("mem_d", bus.mem_d, bus.in_data);
        end
        if (prev_stall) begin
            check("hold_v", bus.out_valid, 1);
            check("hold_d", bus.out_data, prev_data);
        end
        if (pp) begin
            check("pop_nonempty", model_q.size() != 0, 1);
            if (model_q.size() != 0) begin
                check("out_data", bus.out_data, model_q[0]);
                void'(model_q.pop_front());
            end
            pop_total++;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        if (acc) begin
            model_q.push_back(bus.in_data);
            wr_total++;
            next_data = next_data + data_t'(1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r);
        bus.in_valid  = v;
        bus.in_data   = next_data;
        bus.out_ready = r;
        cycle();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && model_q.size() != 0; i++) drive(1'b0, 1'b1);
        check("drain_empty", model_q.size(), 0);
        repeat (3) drive(1'b0, 1'b1);
    endtask

    task automatic fill_to(input int n, input int budget);
        for (int i = 0; i < budget && model_q.size() < n; i++) drive(1'b1, 1'b0);
        check("fill_level", model_q.size(), n);
    endtask

    initial begin
        int base;
        bus.in_valid  = 1'b1;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state (in_valid held high to show in_ready is masked)
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_count", bus.count, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_mem_write", bus.mem_write, 0);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;

        // 1: first word latency
        bus.in_valid  = 1'b1;
        bus.in_data   = 20'h12345;
        bus.out_ready = 1'b0;
        #1;
        check("t1_write", bus.mem_write, 1);
        check("t1_wa", bus.mem_wa, 0);
        cycle();
        check("t1_ov_e0", bus.out_valid, 0);
        drive(1'b0, 1'b0);
        check("t1_ov_e1", bus.out_valid, 0);
        drive(1'b0, 1'b0);
        check("t1_ov_e2", bus.out_valid, 1);
        check("t1_data", bus.out_data, 20'h12345);
        check("t1_count", bus.count, 1);

        // 2: fill to capacity with the output stalled
        fill_to(DEPTH + 2, 1200);
        check("t2_count", bus.count, DEPTH + 2);
        repeat (4) begin
            bus.in_valid = 1'b1;
            #1;
            check("t2_no_write", bus.mem_write, 0);
            check("t2_in_ready", bus.in_ready, 0);
            cycle();
        end
        drain(2000);

        // 3: both sides streaming -> one write per two cycles
        repeat (20) drive(1'b1, 1'b1);
        base = wr_total;
        pop_total = 0;
        repeat (40) drive(1'b1, 1'b1);
        check("t3_wr_rate", (wr_total - base >= 19) && (wr_total - base <= 21), 1);
        check("t3_rd_rate", (pop_total >= 19) && (pop_total <= 21), 1);
        drain(200);

        // 4: 1000 words with random stalls on both sides, pointers wrap
        base = wr_total;
        for (int i = 0; i < 20000 && (wr_total - base) < 1000; i++)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
        check("t4_sent", wr_total - base, 1000);
        drain(2000);

        // 5: output ready toggling with words buffered
        fill_to(4, 50);
        repeat (3) drive(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) drive(1'b0, (i % 2) == 0);
        drain(50);

        // 6: reset mid-stream at count 7
        fill_to(7, 100);
        repeat (3) drive(1'b0, 1'b0);
        check("t6_pre_count", bus.count, 7);
        reset = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check("t6_out_valid", bus.out_valid, 0);
        check("t6_count", bus.count, 0);
        check("t6_in_ready", bus.in_ready, 0);
        check("t6_mem_write", bus.mem_write, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        model_q.delete();
        wr_total   = 0;
        prev_stall = 1'b0;
        next_data  = 20'h0ABCD;
        bus.in_valid = 1'b1;
        bus.in_data  = next_data;
        #1;
        check("t6_wa0", bus.mem_wa, 0);
        check("t6_write", bus.mem_write, 1);
        for (int i = 0; i < 50 && wr_total < 3; i++) drive(1'b1, 1'b1);
        check("t6_sent", wr_total, 3);
        drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
